// File: rtl/approx_mul_share_arbiter_if.sv
// Requester, multiplier-core and result-side signals of the shared multiplier arbiter.
// The slave modport is the arbiter; the master modport is the requesters, core and consumer together.
interface approx_mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_x;
  logic [7:0]        mul_y;
  logic [15:0]       mul_z;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_z;
  logic [IDW-1:0]    res_id;
  logic [15:0]       issue_cnt;

  modport master (
    output req_valid, req_x, req_y, mul_z, res_ready,
    input  req_ready, mul_x, mul_y, res_valid, res_z, res_id, issue_cnt
  );

  modport slave (
    input  req_valid, req_x, req_y, mul_z, res_ready,
    output req_ready, mul_x, mul_y, res_valid, res_z, res_id, issue_cnt
  );
endinterface

// File: rtl/approx_mul_share_arbiter.sv
// Round-robin share of one external 8x8 multiplier core: stage A registers operands, stage B the product.
// Accept-to-result latency 2 edges, 1 result/cycle; res_ready low stalls B, A absorbs one more then blocks.
module approx_mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst,
  approx_mul_share_arbiter_if.slave bus
);
  logic           a_valid;
  logic [IDW-1:0] a_id;
  logic [IDW-1:0] ptr;
  logic           b_load;
  logic           a_adv;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic [7:0]     sel_x;
  logic [7:0]     sel_y;
  logic [NREQ-1:0] ready;
  logic           xfer;
  logic [IDW-1:0] ptr_nxt;
  int             idx;

  assign b_load = !bus.res_valid || bus.res_ready;
  assign a_adv  = !a_valid || b_load;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_x    = bus.req_x[i*8 +: 8];
        sel_y    = bus.req_y[i*8 +: 8];
        ready[i] = !rst && a_adv && gnt_found;
      end
    end
  end

  assign bus.req_ready = ready;
  assign xfer          = |(bus.req_valid & ready);
  assign ptr_nxt       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid       <= 1'b0;
      a_id          <= '0;
      ptr           <= '0;
      bus.mul_x     <= '0;
      bus.mul_y     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_z     <= '0;
      bus.res_id    <= '0;
      bus.issue_cnt <= '0;
    end else begin
      if (b_load) begin
        bus.res_valid <= a_valid;
        // Only a live stage-A entry is allowed to sample the core output.
        if (a_valid) begin
          bus.res_z  <= bus.mul_z;
          bus.res_id <= a_id;
        end
      end
      if (a_adv) begin
        a_valid <= xfer;
        if (xfer) begin
          bus.mul_x     <= sel_x;
          bus.mul_y     <= sel_y;
          a_id          <= gnt_id;
          ptr           <= ptr_nxt;
          bus.issue_cnt <= bus.issue_cnt + 16'd1;
        end
      end
    end
  end
endmodule
